// File: rtl/mod_mem_arbiter_if.sv
// Bus bundle for mod_mem_arbiter: instruction port, data port and memory port.
// slave  : the arbiter's view (requests and m_rdata in, acks/valids/memory strobes out).
// master : the view of whoever drives the CPU requests and models the memory.
interface mod_mem_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) ();
  // Instruction-fetch port
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_ack;
  logic              i_valid;
  logic [DATA_W-1:0] i_rdata;
  // Data-access port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic              d_valid;
  logic [DATA_W-1:0] d_rdata;
  // Memory port
  logic              m_en;
  logic              m_we;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;
  logic [DATA_W-1:0] m_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output i_ack, i_valid, i_rdata, d_ack, d_valid, d_rdata,
    output m_en, m_we, m_addr, m_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  i_ack, i_valid, i_rdata, d_ack, d_valid, d_rdata,
    input  m_en, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mod_mem_arbiter.sv
// mod_mem_arbiter: shares one single-port synchronous-read memory between the
// instruction-fetch and data-access ports. One access in flight at a time:
// IDLE/RESP arbitrate -> ISSUE (m_en + ack) -> WAIT (MEM_LAT cycles) -> RESP (valid).
// All outputs are registered.
// Optional: define MEM_ARB_RR_EN for strict two-way round-robin instead of
// fixed data priority with instruction starvation protection.
module mod_mem_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  mod_mem_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam int unsigned     CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LAT - 1);

  state_e              r_state, w_state_d;
  logic                r_owner, w_owner_d;     // 1 = data port owns the access
  logic                r_we, w_we_d;
  logic [ADDR_W-1:0]   r_addr, w_addr_d;
  logic [DATA_W-1:0]   r_wdata, w_wdata_d;
  logic [CNT_W-1:0]    r_cnt, w_cnt_d;
  logic                r_m_en, w_m_en_d;
  logic                r_i_ack, w_i_ack_d;
  logic                r_d_ack, w_d_ack_d;
  logic                r_i_valid, w_i_valid_d;
  logic                r_d_valid, w_d_valid_d;
  logic [DATA_W-1:0]   r_i_rdata, w_i_rdata_d;
  logic [DATA_W-1:0]   r_d_rdata, w_d_rdata_d;
  logic                w_d_wins;

`ifdef MEM_ARB_RR_EN
  logic                r_last, w_last_d;       // 1 = data won the last arbitration
`else
  localparam int unsigned      STV_W   = $clog2(STARVE_MAX + 1);
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_MAX);
  logic [STV_W-1:0]    r_starve, w_starve_d;
`endif

  // Next-state, arbitration and registered-output decode
  always_comb begin
    w_state_d   = r_state;
    w_owner_d   = r_owner;
    w_we_d      = r_we;
    w_addr_d    = r_addr;
    w_wdata_d   = r_wdata;
    w_cnt_d     = r_cnt;
    w_m_en_d    = 1'b0;
    w_i_ack_d   = 1'b0;
    w_d_ack_d   = 1'b0;
    w_i_valid_d = 1'b0;
    w_d_valid_d = 1'b0;
    w_i_rdata_d = r_i_rdata;
    w_d_rdata_d = r_d_rdata;
`ifdef MEM_ARB_RR_EN
    w_last_d    = r_last;
    // On a tie the port that did not win last time goes first
    w_d_wins    = bus.d_req && !(bus.i_req && r_last);
`else
    w_starve_d  = r_starve;
    // Data has priority unless the instruction port has lost STARVE_MAX times in a row
    w_d_wins    = bus.d_req && !(bus.i_req && (r_starve == STV_MAX));
`endif

    unique case (r_state)
      StIdle, StResp: begin
        if (bus.i_req || bus.d_req) begin
          w_state_d = StIssue;
          w_owner_d = w_d_wins;
          w_m_en_d  = 1'b1;
          if (w_d_wins) begin
            w_we_d    = bus.d_we;
            w_addr_d  = bus.d_addr;
            w_wdata_d = bus.d_wdata;
            w_d_ack_d = 1'b1;
          end else begin
            w_we_d    = 1'b0;
            w_addr_d  = bus.i_addr;
            w_wdata_d = '0;
            w_i_ack_d = 1'b1;
          end
`ifdef MEM_ARB_RR_EN
          w_last_d = w_d_wins;
`else
          if (!w_d_wins) begin
            w_starve_d = '0;
          end else if (bus.i_req && (r_starve != STV_MAX)) begin
            w_starve_d = r_starve + 1'b1;
          end
`endif
        end else begin
          w_state_d = StIdle;
        end
      end
      StIssue: begin
        w_cnt_d   = LAT_LOAD;
        w_state_d = StWait;
      end
      StWait: begin
        if (r_cnt == '0) begin
          // This edge ends cycle ISSUE+MEM_LAT: m_rdata is valid now
          w_state_d = StResp;
          if (r_owner) begin
            w_d_valid_d = 1'b1;
            w_d_rdata_d = r_we ? '0 : bus.m_rdata;
          end else begin
            w_i_valid_d = 1'b1;
            w_i_rdata_d = bus.m_rdata;
          end
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  // State and output registers; reset abandons any access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_owner   <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_cnt     <= '0;
      r_m_en    <= 1'b0;
      r_i_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
`ifdef MEM_ARB_RR_EN
      r_last    <= 1'b1;
`else
      r_starve  <= '0;
`endif
    end else begin
      r_state   <= w_state_d;
      r_owner   <= w_owner_d;
      r_we      <= w_we_d;
      r_addr    <= w_addr_d;
      r_wdata   <= w_wdata_d;
      r_cnt     <= w_cnt_d;
      r_m_en    <= w_m_en_d;
      r_i_ack   <= w_i_ack_d;
      r_d_ack   <= w_d_ack_d;
      r_i_valid <= w_i_valid_d;
      r_d_valid <= w_d_valid_d;
      r_i_rdata <= w_i_rdata_d;
      r_d_rdata <= w_d_rdata_d;
`ifdef MEM_ARB_RR_EN
      r_last    <= w_last_d;
`else
      r_starve  <= w_starve_d;
`endif
    end
  end

  assign bus.m_en    = r_m_en;
  assign bus.m_we    = r_we;
  assign bus.m_addr  = r_addr;
  assign bus.m_wdata = r_wdata;
  assign bus.i_ack   = r_i_ack;
  assign bus.d_ack   = r_d_ack;
  assign bus.i_valid = r_i_valid;
  assign bus.d_valid = r_d_valid;
  assign bus.i_rdata = r_i_rdata;
  assign bus.d_rdata = r_d_rdata;

endmodule

// File: tb/tb_mod_mem_arbiter.sv
// Testbench for mod_mem_arbiter. Two instances: MEM_LAT=1 (main scoreboard) and
// MEM_LAT=3 (latency and reset-during-WAIT). Memory is modelled in the bench.
module tb_mod_mem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst1, rst3;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  // Cycle counter; cycle k is the period that begins at posedge number k
  always @(posedge clk) cyc <= cyc + 1;

  mod_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
  mod_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b3 ();

  mod_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (b1)
  );

  mod_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (b3)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // ---------------- memory model ----------------
  logic [31:0] mem_wr [logic [31:0]];

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    if (mem_wr.exists(a)) return mem_wr[a];
    if (a == 32'h100) return 32'hDEAD_BEEF;
    return {a[15:0], 16'h5A5A} ^ 32'h1357_0000;
  endfunction

  logic        p1_v = 1'b0;
  logic [31:0] p1_d = '0;
  logic [2:0]  p3_v = '0;
  logic [31:0] p3_d [3];

  // Latency-1 memory for dut1; writes land in the shared store
  always @(posedge clk) begin
    if (b1.m_en === 1'b1 && b1.m_we === 1'b1) mem_wr[b1.m_addr] = b1.m_wdata;
    p1_v <= (b1.m_en === 1'b1) && (b1.m_we !== 1'b1);
    p1_d <= mem_val(b1.m_addr);
  end
  assign b1.m_rdata = p1_v ? p1_d : 32'h0BAD_F00D;

  // Latency-3 read pipeline for dut3
  always @(posedge clk) begin
    p3_v    <= {p3_v[1:0], (b3.m_en === 1'b1) && (b3.m_we !== 1'b1)};
    p3_d[0] <= mem_val(b3.m_addr);
    p3_d[1] <= p3_d[0];
    p3_d[2] <= p3_d[1];
  end
  assign b3.m_rdata = p3_v[2] ? p3_d[2] : 32'h0BAD_F00D;

  // ---------------- scoreboard / monitors ----------------
  bit          grant_q [$];   // 1 = data grant expected, 0 = instruction
  logic [31:0] exp_i_q [$];
  logic [31:0] exp_d_q [$];

  int n_ack1 = 0, n_iack1 = 0, n_dack1 = 0, n_men1 = 0, n_iv1 = 0, n_dv1 = 0;
  int ack_cyc1 = 0, iv_cyc1 = 0, dv_cyc1 = 0;
  logic [31:0] last_maddr = '0, last_mwdata = '0;
  logic        last_mwe = 1'b0;

  int n_men3 = 0, n_dack3 = 0, n_dv3 = 0, dack_cyc3 = 0, dv_cyc3 = 0;
  logic [31:0] last_drdata3 = '0;

  // dut1 monitor: grant order, memory strobe capture, read data against the queues
  always @(negedge clk) begin
    if (rst1 === 1'b1) begin
      if (b1.m_en === 1'b1) begin
        n_men1++;
        last_maddr  = b1.m_addr;
        last_mwdata = b1.m_wdata;
        last_mwe    = b1.m_we;
      end
      if (b1.i_ack === 1'b1 || b1.d_ack === 1'b1) begin
        n_ack1++;
        ack_cyc1 = cyc;
        check_eq("ack_onehot", 64'(b1.i_ack & b1.d_ack), 0);
        check_eq("m_en_with_ack", 64'(b1.m_en), 1);
        if (grant_q.size() == 0) check_eq("grant_unexpected", 64'({b1.i_ack, b1.d_ack}), 0);
        else check_eq("grant_order", 64'(b1.d_ack), 64'(grant_q.pop_front()));
        if (b1.i_ack === 1'b1) n_iack1++;
        else n_dack1++;
      end
      if (b1.i_valid === 1'b1) begin
        n_iv1++;
        iv_cyc1 = cyc;
        if (exp_i_q.size() == 0) check_eq("i_valid_unexpected", 64'(b1.i_valid), 0);
        else check_eq("i_rdata", 64'(b1.i_rdata), 64'(exp_i_q.pop_front()));
      end
      if (b1.d_valid === 1'b1) begin
        n_dv1++;
        dv_cyc1 = cyc;
        if (exp_d_q.size() == 0) check_eq("d_valid_unexpected", 64'(b1.d_valid), 0);
        else check_eq("d_rdata", 64'(b1.d_rdata), 64'(exp_d_q.pop_front()));
      end
    end
  end

  // dut3 monitor: event counts and timestamps
  always @(negedge clk) begin
    if (rst3 === 1'b1) begin
      if (b3.m_en === 1'b1) n_men3++;
      if (b3.d_ack === 1'b1) begin
        n_dack3++;
        dack_cyc3 = cyc;
      end
      if (b3.d_valid === 1'b1) begin
        n_dv3++;
        dv_cyc3      = cyc;
        last_drdata3 = b3.d_rdata;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int t0, a0, prev, m0, i0, v0;
    bit g;
    rst1 = 1'b0;
    rst3 = 1'b0;
    b1.i_req = 0; b1.i_addr = '0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = '0; b1.d_wdata = '0;
    b3.i_req = 0; b3.i_addr = '0; b3.d_req = 0; b3.d_we = 0; b3.d_addr = '0; b3.d_wdata = '0;
    repeat (2) tick();
    check_eq("rst_strobes1", 64'({b1.i_ack, b1.i_valid, b1.d_ack, b1.d_valid, b1.m_en, b1.m_we}), 0);
    check_eq("rst_maddr1", 64'(b1.m_addr), 0);
    check_eq("rst_rdata1", {b1.i_rdata, b1.d_rdata}, 0);
    rst1 = 1'b1;
    rst3 = 1'b1;
    repeat (2) tick();

    // Single instruction read: ack and m_en in cycle 1, valid in cycle 3
    t0 = cyc;
    b1.i_req = 1'b1; b1.i_addr = 32'h100;
    grant_q.push_back(1'b0); exp_i_q.push_back(32'hDEAD_BEEF);
    a0 = n_iack1;
    for (int k = 0; k < 20 && n_iack1 == a0; k++) tick();
    check_eq("i_ack_seen", 64'(n_iack1 != a0), 1);
    b1.i_req = 1'b0;
    check_eq("i_ack_latency", 64'(ack_cyc1 - t0), 1);
    check_eq("i_m_addr", 64'(last_maddr), 64'h100);
    a0 = n_iv1;
    for (int k = 0; k < 20 && n_iv1 == a0; k++) tick();
    check_eq("i_valid_seen", 64'(n_iv1 != a0), 1);
    check_eq("i_valid_latency", 64'(iv_cyc1 - ack_cyc1), 2);
    tick();

    // Data write: single m_en with m_we, d_rdata 0, no instruction ack
    m0 = n_men1; i0 = n_iack1;
    b1.d_req = 1'b1; b1.d_we = 1'b1; b1.d_addr = 32'h40; b1.d_wdata = 32'h1234_5678;
    grant_q.push_back(1'b1); exp_d_q.push_back(32'h0);
    a0 = n_dack1;
    for (int k = 0; k < 20 && n_dack1 == a0; k++) tick();
    check_eq("d_ack_seen", 64'(n_dack1 != a0), 1);
    b1.d_req = 1'b0; b1.d_we = 1'b0;
    a0 = n_dv1;
    for (int k = 0; k < 20 && n_dv1 == a0; k++) tick();
    check_eq("d_valid_seen", 64'(n_dv1 != a0), 1);
    repeat (3) tick();
    check_eq("wr_m_en_count", 64'(n_men1 - m0), 1);
    check_eq("wr_m_we", 64'(last_mwe), 1);
    check_eq("wr_m_addr", 64'(last_maddr), 64'h40);
    check_eq("wr_m_wdata", 64'(last_mwdata), 64'h1234_5678);
    check_eq("wr_no_i_ack", 64'(n_iack1 - i0), 0);

    // Read back the written word through the data port
    b1.d_req = 1'b1; b1.d_addr = 32'h40;
    grant_q.push_back(1'b1); exp_d_q.push_back(32'h1234_5678);
    a0 = n_dack1;
    for (int k = 0; k < 20 && n_dack1 == a0; k++) tick();
    check_eq("rd_ack_seen", 64'(n_dack1 != a0), 1);
    b1.d_req = 1'b0;
    a0 = n_dv1;
    for (int k = 0; k < 20 && n_dv1 == a0; k++) tick();
    check_eq("rd_valid_seen", 64'(n_dv1 != a0), 1);
    repeat (2) tick();

    // Both ports held: grant pattern and MEM_LAT+2 back-to-back spacing
    b1.i_addr = 32'h200; b1.d_addr = 32'h300; b1.d_we = 1'b0;
    for (int k = 0; k < 10; k++) begin
`ifdef MEM_ARB_RR_EN
      g = (k % 2) == 1;
`else
      g = (k % 5) != 4;
`endif
      grant_q.push_back(g);
      if (g) exp_d_q.push_back(mem_val(32'h300));
      else   exp_i_q.push_back(mem_val(32'h200));
    end
    b1.i_req = 1'b1; b1.d_req = 1'b1;
    prev = 0;
    for (int n = 0; n < 10; n++) begin
      a0 = n_ack1;
      for (int k = 0; k < 20 && n_ack1 == a0; k++) tick();
      check_eq("cont_ack_seen", 64'(n_ack1 != a0), 1);
      if (n > 0) check_eq("b2b_period", 64'(ack_cyc1 - prev), 3);
      prev = ack_cyc1;
    end
    b1.i_req = 1'b0; b1.d_req = 1'b0;
    for (int k = 0; k < 20 && (exp_i_q.size() + exp_d_q.size()) != 0; k++) tick();
    repeat (3) tick();
    check_eq("sb_drained", 64'(exp_i_q.size() + exp_d_q.size() + grant_q.size()), 0);

    // MEM_LAT=3 read: valid lands 4 cycles after the ack cycle (5th cycle counting it)
    m0 = n_men3;
    b3.d_req = 1'b1; b3.d_we = 1'b0; b3.d_addr = 32'h80;
    a0 = n_dack3;
    for (int k = 0; k < 20 && n_dack3 == a0; k++) tick();
    check_eq("l3_ack_seen", 64'(n_dack3 != a0), 1);
    b3.d_req = 1'b0;
    a0 = n_dv3;
    for (int k = 0; k < 20 && n_dv3 == a0; k++) tick();
    check_eq("l3_valid_seen", 64'(n_dv3 != a0), 1);
    check_eq("l3_valid_latency", 64'(dv_cyc3 - dack_cyc3), 4);
    check_eq("l3_rdata", 64'(last_drdata3), 64'(mem_val(32'h80)));
    repeat (2) tick();
    check_eq("l3_m_en_count", 64'(n_men3 - m0), 1);

    // Reset asserted during WAIT: outputs clear at once, abandoned access never completes
    b3.d_req = 1'b1; b3.d_addr = 32'h88;
    a0 = n_dack3;
    for (int k = 0; k < 20 && n_dack3 == a0; k++) tick();
    check_eq("rw_ack_seen", 64'(n_dack3 != a0), 1);
    b3.d_req = 1'b0;
    v0 = n_dv3;
    tick();
    rst3 = 1'b0;
    #1;
    check_eq("rw_async_strobes",
             64'({b3.i_ack, b3.i_valid, b3.d_ack, b3.d_valid, b3.m_en, b3.m_we}), 0);
    check_eq("rw_async_maddr", 64'(b3.m_addr), 0);
    check_eq("rw_async_rdata", 64'(b3.d_rdata), 0);
    repeat (2) tick();
    rst3 = 1'b1;
    repeat (8) tick();
    check_eq("rw_no_stale_valid", 64'(n_dv3 - v0), 0);
    b3.d_req = 1'b1; b3.d_addr = 32'h8C;
    a0 = n_dack3;
    for (int k = 0; k < 20 && n_dack3 == a0; k++) tick();
    check_eq("rw_next_ack_seen", 64'(n_dack3 != a0), 1);
    b3.d_req = 1'b0;
    a0 = n_dv3;
    for (int k = 0; k < 20 && n_dv3 == a0; k++) tick();
    check_eq("rw_next_valid_seen", 64'(n_dv3 != a0), 1);
    check_eq("rw_next_rdata", 64'(last_drdata3), 64'(mem_val(32'h8C)));
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
